// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller: FSM state encoding
// and the bundled load/flush control word.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DMEM_WAIT = 2'd1,
    DROP_IMEM = 2'd2
  } pipe_ctrl_state_t;

  typedef struct packed {
    logic pc_load;
    logic if_id_load;
    logic id_ex_load;
    logic ex_mem_load;
    logic mem_wb_load;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
  } pipe_ctrl_t;

  localparam int unsigned REG_IDX_W = 5;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard comparator (combinational). Kept separate so the forwarding
// unit can reuse the same match logic.
module hazard_detect
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned NOP_SAFE_RD = 0
) (
  input  logic                 ex_is_load_i,
  input  logic [REG_IDX_W-1:0] ex_rd_i,
  input  logic [REG_IDX_W-1:0] id_rs1_i,
  input  logic [REG_IDX_W-1:0] id_rs2_i,
  output logic                 luse_o
);

  localparam logic [REG_IDX_W-1:0] SAFE_RD = REG_IDX_W'(NOP_SAFE_RD);

  always_comb begin
    luse_o = ex_is_load_i && (ex_rd_i != SAFE_RD) &&
             ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller for the five-stage RV32I pipeline.
// Optional performance counters are enabled with `define PIPE_CTRL_PERF_EN.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned NOP_SAFE_RD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 imem_resp,
  input  logic                 dmem_req,
  input  logic                 dmem_resp,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_is_load,
  input  logic                 pcmuxsel,
  output logic                 pc_load,
  output logic                 if_id_load,
  output logic                 id_ex_load,
  output logic                 ex_mem_load,
  output logic                 mem_wb_load,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 ex_mem_flush,
  output logic [1:0]           state_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]          stall_cycles,
  output logic [31:0]          flush_events
`endif
);

  pipe_ctrl_state_t state_q, state_d;
  pipe_ctrl_t       ctrl, ctrl_out;
  logic             dstall, istall, luse;

  assign dstall = dmem_req && !dmem_resp;
  assign istall = !imem_resp;

  hazard_detect #(
    .NOP_SAFE_RD(NOP_SAFE_RD)
  ) u_hazard (
    .ex_is_load_i(ex_is_load),
    .ex_rd_i     (ex_rd),
    .id_rs1_i    (id_rs1),
    .id_rs2_i    (id_rs2),
    .luse_o      (luse)
  );

  // Priority chain; DMEM_WAIT without dstall falls through to the lower rules,
  // and a redirect held by MEM/WB during a stall is picked up on release.
  always_comb begin
    ctrl    = '0;
    state_d = RUN;
    if (dstall) begin
      state_d = DMEM_WAIT;
    end else if (pcmuxsel) begin
      ctrl    = '1;
      state_d = istall ? DROP_IMEM : RUN;
    end else if (state_q == DROP_IMEM) begin
      ctrl             = '1;
      ctrl.pc_load     = 1'b0;
      ctrl.id_ex_flush = 1'b0;
      ctrl.ex_mem_flush = 1'b0;
      state_d          = imem_resp ? RUN : DROP_IMEM;
    end else if (luse) begin
      ctrl.id_ex_load  = 1'b1;
      ctrl.ex_mem_load = 1'b1;
      ctrl.mem_wb_load = 1'b1;
      ctrl.id_ex_flush = 1'b1;
    end else if (istall) begin
      ctrl              = '1;
      ctrl.pc_load      = 1'b0;
      ctrl.id_ex_flush  = 1'b0;
      ctrl.ex_mem_flush = 1'b0;
    end else begin
      ctrl.pc_load     = 1'b1;
      ctrl.if_id_load  = 1'b1;
      ctrl.id_ex_load  = 1'b1;
      ctrl.ex_mem_load = 1'b1;
      ctrl.mem_wb_load = 1'b1;
    end
  end

  // Reset freezes the whole pipeline, independent of the inputs.
  assign ctrl_out = rst_n ? ctrl : '0;

  assign pc_load      = ctrl_out.pc_load;
  assign if_id_load   = ctrl_out.if_id_load;
  assign id_ex_load   = ctrl_out.id_ex_load;
  assign ex_mem_load  = ctrl_out.ex_mem_load;
  assign mem_wb_load  = ctrl_out.mem_wb_load;
  assign if_id_flush  = ctrl_out.if_id_flush;
  assign id_ex_flush  = ctrl_out.id_ex_flush;
  assign ex_mem_flush = ctrl_out.ex_mem_flush;
  assign state_o      = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_q, flush_events_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      if (!ctrl.pc_load) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (!dstall && pcmuxsel) begin
        flush_events_q <= flush_events_q + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`endif

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush controller for the five-stage RV32I pipeline. It drives the load and bubble-insert (flush) strobes of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB registers. Its inputs are memory handshakes, a load-use hazard check, and the MEM/WB redirect (`pcmuxsel`). Two pieces of tracked state make it sequential: waits on an outstanding data access, and the discard of one stale instruction-fetch response after a redirect.

## Interface
Parameters:
- `NOP_SAFE_RD`, default 0: register index that never creates a hazard (x0).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `imem_resp`  in  1  instruction memory returned data this cycle.
- `dmem_req`  in  1  EX/MEM holds a load or store (from its control word).
- `dmem_resp`  in  1  data memory completed the access this cycle.
- `id_rs1`, `id_rs2`  in  5  source registers of the IF/ID instruction.
- `ex_rd`  in  5  destination register of the ID/EX instruction.
- `ex_is_load`  in  1  ID/EX instruction opcode is `op_load`.
- `pcmuxsel`  in  1  MEM/WB redirect: a jal, a jalr, or a taken branch.
- `pc_load`, `if_id_load`, `id_ex_load`, `ex_mem_load`, `mem_wb_load`  out  1 each  register load enables.
- `if_id_flush`, `id_ex_flush`, `ex_mem_flush`  out  1 each  on this edge the register captures a bubble (zero instruction/control word) instead of its input; the bubble overrides load.
- `state_o`  out  2  current FSM state, for debug.

## Operation
- FSM states: `RUN`=0, `DMEM_WAIT`=1, `DROP_IMEM`=2.
- Hazard terms:
  - dstall = `dmem_req` & !`dmem_resp`.
  - luse = `ex_is_load` & (`ex_rd` != `NOP_SAFE_RD`) & (`ex_rd` == `id_rs1` | `ex_rd` == `id_rs2`).
  - istall = !`imem_resp`.
- Priority, highest first; the first rule that matches applies:
  1. dstall (any state): all loads 0, all flushes 0. Go to `DMEM_WAIT`, or stay there. A `pcmuxsel` seen here is deferred, not lost.
  2. `pcmuxsel`: all loads 1, and `if_id_flush` = `id_ex_flush` = `ex_mem_flush` = 1. If istall is also true, go to `DROP_IMEM`; otherwise go to `RUN`.
  3. State `DROP_IMEM`: `pc_load` 0, `if_id_flush` 1, other loads 1. When `imem_resp` arrives, that response is discarded and the FSM goes to `RUN`.
  4. luse: `pc_load` = `if_id_load` = 0, `id_ex_flush` 1, `ex_mem_load` = `mem_wb_load` = 1.
  5. istall: `pc_load` 0, `if_id_flush` 1, other loads 1.
  6. Otherwise: all loads 1, all flushes 0.
- `DMEM_WAIT` exits to `RUN` in the cycle `dmem_resp` is 1. That cycle is then evaluated by rules 2–6.
- A `dmem_resp` that arrives without `dmem_req` is ignored.

## Timing
- All load/flush outputs are combinational from the current state and inputs, settled before the same rising edge. State is registered, so the FSM has 1 cycle of latency.
- Reset (`rst_n` low, asynchronous): state = `RUN`, and every output is forced to 0 (loads and flushes) regardless of inputs. The pipeline freezes.
- Reset deassertion is synchronized by the user. On the first edge after release, normal evaluation applies.
- Reset asserted mid-wait (`DMEM_WAIT` or `DROP_IMEM`) returns the FSM to `RUN` immediately; no pending drop survives.
- A redirect flushes exactly 3 younger instructions in one edge.
- A load-use hazard costs exactly 1 bubble cycle.
- A data stall costs N cycles, where N is the number of cycles with `dmem_resp` = 0.
- `pcmuxsel` together with luse: the redirect wins and no bubble is double-counted.

## Configuration
- `PIPE_CTRL_PERF_EN` defined: adds outputs `stall_cycles` (32, out) and `flush_events` (32, out). Both reset to 0 and wrap modulo 2^32.
  - `stall_cycles` +1 for each cycle in which `pc_load` = 0.
  - `flush_events` +1 for each accepted redirect (rule 2).
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Add to `rv32i_types`: enum `pipe_ctrl_state_t` {`RUN`, `DMEM_WAIT`, `DROP_IMEM`}, and a packed struct `pipe_ctrl_t` bundling the 5 loads and 3 flushes.
- Single module. The hazard comparator lives in its own sub-module `hazard_detect` (combinational, luse only) so the forwarding unit can reuse it.

## Test plan
- Load-use: `ex_is_load`=1, `ex_rd`=5, `id_rs1`=5, all responses 1 → one cycle with `pc_load`=0, `if_id_load`=0, `id_ex_flush`=1; the next cycle has all loads 1.
- x0 suppression: same stimulus with `ex_rd`=0 → no stall.
- Data stall: `dmem_req`=1 with `dmem_resp` low for 3 cycles → all loads 0 for 3 cycles and `state_o`=1; on the 4th cycle `dmem_resp`=1 gives all loads 1 and `state_o`=0 next.
- Redirect with fetch outstanding: `pcmuxsel`=1, `imem_resp`=0 → three flushes high for 1 cycle, then `state_o`=2. Two cycles of `if_id_flush`=1, then `imem_resp`=1 → `RUN`.
- Deferred redirect: `pcmuxsel`=1 during dstall → no flush until `dmem_resp`=1, then flush on that cycle.
- Reset: assert `rst_n`=0 while in `DROP_IMEM` → outputs 0 immediately, state 0; with `PIPE_CTRL_PERF_EN` defined, both counters read 0.
